// File: rtl/counter_down_mod.sv
// counter_down_mod
// ----------------
// Parametrised synchronous modulo-N down counter for the timer datapath.
// Instances chain through rco_L -> enablen to form multi-digit timers.
// For example, a seconds-units mod-10 stage can feed a seconds-tens mod-6 stage.
//
// Parameters:
//   WIDTH    bit width of in/count (2^WIDTH >= MODULUS)
//   MODULUS  count range 0..MODULUS-1 (2..2^WIDTH)
//   WRAP     1: wrap 0 -> MODULUS-1 on decrement, 0: hold at 0
//   CLAMP    out-of-range load: 0 = ignore and flag, 1 = load MODULUS-1 and flag
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   enablen   in   active-low count enable (upstream rco_L when cascading)
//   load      in   synchronous parallel load, wins over enablen
//   in        in   parallel load value
//   count     out  registered count
//   rco_L     out  active-low borrow out, combinational
//   zero      out  count == 0
//   done      out  one-cycle pulse after an enabled 1 -> 0 decrement
//   load_err  out  one-cycle pulse after an out-of-range load
module counter_down_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6,
  parameter bit WRAP    = 1'b1,
  parameter bit CLAMP   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enablen,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count,
  output logic             rco_L,
  output logic             zero,
  output logic             done,
  output logic             load_err
);

  // One extra bit so that MODULUS == 2^WIDTH is still representable.
  localparam logic [WIDTH:0]   L_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_done;
  logic             r_load_err;

  logic             w_zero;
  logic             w_in_legal;
  logic             w_count_en;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;

  assign w_zero     = (r_count == '0);
  assign w_in_legal = ({1'b0, in} < L_MOD);
  assign w_count_en = ~load & ~enablen;

  always_comb begin
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (load) begin
      w_err_nxt = ~w_in_legal;
      if (w_in_legal) begin
        w_count_nxt = in;
      end else if (CLAMP) begin
        w_count_nxt = L_MAX;
      end
    end else if (!enablen) begin
      if (!w_zero) begin
        w_count_nxt = r_count - WIDTH'(1);
        // Only a genuine 1 -> 0 step reports done; wraps and holds at 0 do not.
        w_done_nxt  = (r_count == WIDTH'(1));
      end else if (WRAP) begin
        w_count_nxt = L_MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_err_nxt;
    end
  end

  // Borrow is held inactive during reset so a downstream stage never sees a
  // spurious enable while the chain is being cleared. In stop-at-zero mode it
  // still fires on every enabled cycle at 0; the top of a chain must be gated.
  assign rco_L    = ~(rst & w_count_en & w_zero);
  assign count    = r_count;
  assign zero     = w_zero;
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_counter_down_mod.sv
module tb_counter_down_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       enablen;
  logic       load;
  logic [3:0] s_in;

  // index 0: wrap/ignore, 1: wrap/clamp, 2: stop-at-zero/ignore (all mod 6)
  logic [3:0] cnt [3];
  logic       rco [3];
  logic       zro [3];
  logic       dn  [3];
  logic       er  [3];

  // cascade: units mod 10 feeding tens mod 6
  logic       u_enablen, u_load, t_load;
  logic [3:0] u_in, u_cnt;
  logic [2:0] t_in, t_cnt;
  logic       u_rco, u_zero, u_done, u_err;
  logic       t_rco, t_zero, t_done, t_err;

  int checks   = 0;
  int failures = 0;

  int mod_a   [3] = '{6, 6, 6};
  int wrap_a  [3] = '{1, 1, 0};
  int clamp_a [3] = '{0, 1, 0};
  int m_cnt   [3];
  int m_dn    [3];
  int m_er    [3];

  always #5 clk = ~clk;

  counter_down_mod #(.WIDTH(4), .MODULUS(6), .WRAP(1), .CLAMP(0)) dut_main (
    .clk(clk), .rst(rst), .enablen(enablen), .load(load), .in(s_in),
    .count(cnt[0]), .rco_L(rco[0]), .zero(zro[0]), .done(dn[0]), .load_err(er[0]));

  counter_down_mod #(.WIDTH(4), .MODULUS(6), .WRAP(1), .CLAMP(1)) dut_clamp (
    .clk(clk), .rst(rst), .enablen(enablen), .load(load), .in(s_in),
    .count(cnt[1]), .rco_L(rco[1]), .zero(zro[1]), .done(dn[1]), .load_err(er[1]));

  counter_down_mod #(.WIDTH(4), .MODULUS(6), .WRAP(0), .CLAMP(0)) dut_stop (
    .clk(clk), .rst(rst), .enablen(enablen), .load(load), .in(s_in),
    .count(cnt[2]), .rco_L(rco[2]), .zero(zro[2]), .done(dn[2]), .load_err(er[2]));

  counter_down_mod #(.WIDTH(4), .MODULUS(10), .WRAP(1), .CLAMP(0)) dut_units (
    .clk(clk), .rst(rst), .enablen(u_enablen), .load(u_load), .in(u_in),
    .count(u_cnt), .rco_L(u_rco), .zero(u_zero), .done(u_done), .load_err(u_err));

  counter_down_mod #(.WIDTH(3), .MODULUS(6), .WRAP(1), .CLAMP(0)) dut_tens (
    .clk(clk), .rst(rst), .enablen(u_rco), .load(t_load), .in(t_in),
    .count(t_cnt), .rco_L(t_rco), .zero(t_zero), .done(t_done), .load_err(t_err));

  task automatic drive(input logic ld, input logic en_n, input logic [3:0] v);
    load = ld; enablen = en_n; s_in = v;
  endtask

  task automatic cycle();
    @(posedge clk); #2;
  endtask

  // Reference: one clock edge of a modulo-N down counter, from the rules.
  task automatic model_step(input int k, input bit ld, input bit en_n, input int v);
    m_dn[k] = 0;
    m_er[k] = 0;
    if (ld) begin
      if (v < mod_a[k]) m_cnt[k] = v;
      else begin
        m_er[k] = 1;
        if (clamp_a[k] != 0) m_cnt[k] = mod_a[k] - 1;
      end
    end else if (!en_n) begin
      if (m_cnt[k] == 1) m_dn[k] = 1;
      if (m_cnt[k] > 0 || wrap_a[k] != 0) m_cnt[k] = (m_cnt[k] + mod_a[k] - 1) % mod_a[k];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0);
    u_enablen = 1'b1; u_load = 1'b0; t_load = 1'b0; u_in = 4'd0; t_in = 3'd0;
    repeat (3) cycle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (cnt[k] !== 4'd0) begin failures++; $display("FAIL reset_count[%0d] got=%0d exp=0", k, cnt[k]); end
      checks++; if (rco[k] !== 1'b1) begin failures++; $display("FAIL reset_rco[%0d] got=%b exp=1", k, rco[k]); end
      checks++; if (zro[k] !== 1'b1) begin failures++; $display("FAIL reset_zero[%0d] got=%b exp=1", k, zro[k]); end
      checks++; if (dn[k] !== 1'b0 || er[k] !== 1'b0) begin failures++; $display("FAIL reset_flags[%0d] got=%b%b exp=00", k, dn[k], er[k]); end
    end
    rst = 1'b1;
    #1;
    checks++; if (rco[0] !== 1'b0) begin failures++; $display("FAIL release_rco got=%b exp=0", rco[0]); end
  endtask

  task automatic test_countdown();
    int seq [6] = '{4, 3, 2, 1, 0, 5};
    drive(1'b1, 1'b1, 4'd5);
    cycle();
    checks++; if (cnt[0] !== 4'd5) begin failures++; $display("FAIL load5 got=%0d exp=5", cnt[0]); end
    drive(1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (cnt[0] !== 4'(seq[i])) begin failures++; $display("FAIL countdown[%0d] got=%0d exp=%0d", i, cnt[0], seq[i]); end
      checks++; if (dn[0] !== (seq[i] == 0)) begin failures++; $display("FAIL countdown_done[%0d] got=%b exp=%b", i, dn[0], seq[i] == 0); end
      checks++; if (rco[0] !== (seq[i] != 0)) begin failures++; $display("FAIL countdown_rco[%0d] got=%b exp=%b", i, rco[0], seq[i] != 0); end
      checks++; if (zro[0] !== (seq[i] == 0)) begin failures++; $display("FAIL countdown_zero[%0d] got=%b exp=%b", i, zro[0], seq[i] == 0); end
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 4'd2);
    cycle();
    drive(1'b1, 1'b1, 4'd9);
    cycle();
    checks++; if (cnt[0] !== 4'd2) begin failures++; $display("FAIL oor_ignore_count got=%0d exp=2", cnt[0]); end
    checks++; if (er[0] !== 1'b1) begin failures++; $display("FAIL oor_ignore_err got=%b exp=1", er[0]); end
    checks++; if (cnt[1] !== 4'd5) begin failures++; $display("FAIL oor_clamp_count got=%0d exp=5", cnt[1]); end
    checks++; if (er[1] !== 1'b1) begin failures++; $display("FAIL oor_clamp_err got=%b exp=1", er[1]); end
    drive(1'b0, 1'b1, 4'd0);
    cycle();
    checks++; if (er[0] !== 1'b0 || er[1] !== 1'b0) begin failures++; $display("FAIL oor_err_pulse got=%b%b exp=00", er[0], er[1]); end
    checks++; if (cnt[0] !== 4'd2 || cnt[1] !== 4'd5) begin failures++; $display("FAIL oor_hold got=%0d,%0d exp=2,5", cnt[0], cnt[1]); end
  endtask

  task automatic test_load_vs_enable();
    drive(1'b1, 1'b0, 4'd3);
    #1;
    checks++; if (rco[0] !== 1'b1) begin failures++; $display("FAIL load_rco got=%b exp=1", rco[0]); end
    cycle();
    checks++; if (cnt[0] !== 4'd3) begin failures++; $display("FAIL load_with_enable got=%0d exp=3", cnt[0]); end
    drive(1'b1, 1'b1, 4'd4);
    cycle();
    checks++; if (cnt[0] !== 4'd4) begin failures++; $display("FAIL load_without_enable got=%0d exp=4", cnt[0]); end
    drive(1'b1, 1'b0, 4'd0);
    cycle();
    checks++; if (cnt[0] !== 4'd0 || dn[0] !== 1'b0) begin failures++; $display("FAIL load_zero got=%0d/%b exp=0/0", cnt[0], dn[0]); end
    drive(1'b0, 1'b1, 4'd0);
    cycle();
  endtask

  task automatic test_stop_zero();
    int dexp [3] = '{1, 0, 0};
    drive(1'b1, 1'b0, 4'd1);
    cycle();
    checks++; if (cnt[2] !== 4'd1) begin failures++; $display("FAIL stop_load got=%0d exp=1", cnt[2]); end
    drive(1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (cnt[2] !== 4'd0 || zro[2] !== 1'b1) begin failures++; $display("FAIL stop_count[%0d] got=%0d/%b exp=0/1", i, cnt[2], zro[2]); end
      checks++; if (dn[2] !== dexp[i][0]) begin failures++; $display("FAIL stop_done[%0d] got=%b exp=%0d", i, dn[2], dexp[i]); end
      checks++; if (rco[2] !== 1'b0) begin failures++; $display("FAIL stop_rco[%0d] got=%b exp=0", i, rco[2]); end
    end
    drive(1'b0, 1'b1, 4'd0);
    cycle();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 4'd4);
    cycle();
    rst = 1'b0;
    #1;
    checks++; if (cnt[0] !== 4'd0) begin failures++; $display("FAIL async_clear got=%0d exp=0", cnt[0]); end
    drive(1'b0, 1'b0, 4'd0);
    #1;
    checks++; if (rco[0] !== 1'b1) begin failures++; $display("FAIL rco_in_reset got=%b exp=1", rco[0]); end
    rst = 1'b1;
    cycle();
    checks++; if (cnt[0] !== 4'd5 || dn[0] !== 1'b0) begin failures++; $display("FAIL post_reset_wrap got=%0d/%b exp=5/0", cnt[0], dn[0]); end
    drive(1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_cascade();
    int val;
    u_enablen = 1'b1; u_load = 1'b1; u_in = 4'd0; t_load = 1'b1; t_in = 3'd2;
    cycle();
    u_load = 1'b0; t_load = 1'b0;
    val = 20;
    checks++; if (int'(t_cnt) * 10 + int'(u_cnt) != val) begin failures++; $display("FAIL cascade_load got=%0d%0d exp=20", t_cnt, u_cnt); end
    u_enablen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      val = (val + 59) % 60;
      checks++;
      if (int'(t_cnt) != val / 10 || int'(u_cnt) != val % 10) begin
        failures++; $display("FAIL cascade[%0d] got=%0d%0d exp=%0d", i, t_cnt, u_cnt, val);
      end
    end
    u_enablen = 1'b1;
  endtask

  task automatic test_random();
    bit ld, en_n;
    int v;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_dn[k] = 0; m_er[k] = 0; end
    for (int i = 0; i < 300; i++) begin
      ld   = ($urandom_range(0, 4) == 0);
      en_n = ($urandom_range(0, 3) == 0);
      v    = int'($urandom_range(0, 15));
      drive(ld, en_n, 4'(v));
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rco[k] !== !(!ld && !en_n && m_cnt[k] == 0)) begin
          failures++; $display("FAIL rand_rco[%0d] i=%0d got=%b cnt_model=%0d", k, i, rco[k], m_cnt[k]);
        end
      end
      @(posedge clk); #2;
      for (int k = 0; k < 3; k++) begin
        model_step(k, ld, en_n, v);
        checks++;
        if (cnt[k] !== 4'(m_cnt[k]) || dn[k] !== m_dn[k][0] || er[k] !== m_er[k][0] || zro[k] !== (m_cnt[k] == 0)) begin
          failures++;
          $display("FAIL rand_state[%0d] i=%0d got=%0d/%b/%b/%b exp=%0d/%0d/%0d/%b",
                   k, i, cnt[k], dn[k], er[k], zro[k], m_cnt[k], m_dn[k], m_er[k], m_cnt[k] == 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_out_of_range();
    test_load_vs_enable();
    test_stop_zero();
    test_async_reset();
    test_cascade();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
